// File: rtl/audio_codec_pkg.sv
// audio_codec_pkg: shared I2S defaults, slot encoding and sample type for the codec paths
package audio_codec_pkg;
   localparam int SAMPLE_BITS = 16;
   localparam int SLOT_BITS   = 32;
   localparam int BCLK_HALF   = 16;
   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} slot_e;
   typedef logic signed [SAMPLE_BITS-1:0] sample_t;
endpackage

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: I2S master bit/frame clock generator with edge strobes and bit index
module i2s_clock_gen
   import audio_codec_pkg::*;
#(
   parameter int BCLK_HALF = audio_codec_pkg::BCLK_HALF,
   parameter int SLOT_BITS = audio_codec_pkg::SLOT_BITS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   output logic                         bclk,
   output logic                         lrck,
   output logic                         rise_stb,
   output logic                         fall_stb,
   output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
   output slot_e                        slot
);
   localparam int DW = $clog2(BCLK_HALF);
   localparam int BW = $clog2(SLOT_BITS);
   logic [DW-1:0] div;
   logic          wrap;
   logic          last_bit;
   assign wrap     = div == DW'(BCLK_HALF - 1);
   assign last_bit = bit_idx == BW'(SLOT_BITS - 1);
   // strobes are registered: each is high in the first clk cycle after its bclk edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         slot <= IDLE; div <= '0; bit_idx <= '0; bclk <= 1'b0; lrck <= 1'b0; rise_stb <= 1'b0; fall_stb <= 1'b0;
      end else if (!enable) begin
         slot <= IDLE; div <= '0; bit_idx <= '0; bclk <= 1'b0; lrck <= 1'b0; rise_stb <= 1'b0; fall_stb <= 1'b0;
      end else begin
         rise_stb <= slot != IDLE && wrap && !bclk;
         fall_stb <= slot != IDLE && wrap && bclk;
         if (slot == IDLE) slot <= LEFT;
         else begin
            div <= wrap ? '0 : div + 1'b1;
            if (wrap) bclk <= !bclk;
            if (wrap && bclk) begin
               bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
               if (last_bit) begin
                  slot <= slot == LEFT ? RIGHT : LEFT;
                  lrck <= !lrck;
               end
            end
         end
      end
endmodule

// File: rtl/audio_codec_input.sv
// audio_codec_input: I2S master receive path delivering left/right ADC sample pairs over valid/ready
module audio_codec_input
   import audio_codec_pkg::*;
#(
   parameter int BCLK_HALF   = audio_codec_pkg::BCLK_HALF,
   parameter int SLOT_BITS   = audio_codec_pkg::SLOT_BITS,
   parameter int SAMPLE_BITS = audio_codec_pkg::SAMPLE_BITS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   output logic                          adc_bclk,
   output logic                          adc_lrck,
   input  logic                          adc_data,
   output logic signed [SAMPLE_BITS-1:0] sample_left,
   output logic signed [SAMPLE_BITS-1:0] sample_right,
   output logic                          sample_valid,
   input  logic                          sample_ready,
   output logic                          overrun,
   input  logic                          clear_overrun
);
   localparam int BW = $clog2(SLOT_BITS);
   logic                   rise_stb, fall_stb, din_q;
   logic [BW-1:0]          bit_idx;
   slot_e                  slot;
   logic [SAMPLE_BITS-1:0] shift, shadow, word;
   logic                   cap, last_cap, pair_done;
   i2s_clock_gen #(.BCLK_HALF(BCLK_HALF), .SLOT_BITS(SLOT_BITS)) u_clk (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bclk(adc_bclk), .lrck(adc_lrck),
      .rise_stb(rise_stb), .fall_stb(fall_stb), .bit_idx(bit_idx), .slot(slot)
   );
   assign word      = {shift[SAMPLE_BITS-2:0], din_q};
   assign cap       = rise_stb && bit_idx >= BW'(1) && bit_idx <= BW'(SAMPLE_BITS);
   assign last_cap  = rise_stb && bit_idx == BW'(SAMPLE_BITS);
   assign pair_done = last_cap && slot == RIGHT;
   // bit 0 of each slot is the I2S delay bit; the word starts clean at every slot boundary
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         din_q <= 1'b0; shift <= '0; shadow <= '0; sample_left <= '0; sample_right <= '0;
         sample_valid <= 1'b0; overrun <= 1'b0;
      end else begin
         din_q <= adc_data;
         if (cap) shift <= word;
         else if (fall_stb && bit_idx == '0) shift <= '0;
         if (last_cap && slot == LEFT) shadow <= word;
         if (pair_done && (!sample_valid || sample_ready)) begin
            sample_left  <= shadow;
            sample_right <= word;
            sample_valid <= 1'b1;
         end else if (sample_valid && sample_ready) sample_valid <= 1'b0;
         if (pair_done && sample_valid && !sample_ready) overrun <= 1'b1;
         else if (clear_overrun) overrun <= 1'b0;
      end
endmodule

// File: tb/tb_audio_codec_input.sv
// tb_audio_codec_input: directed table and sequence checks of the I2S receive path against a codec model
module tb_audio_codec_input;
   logic clk = 0, rst_n = 0, enable = 0, adc_data = 0, sample_ready = 0, clear_overrun = 0;
   logic adc_bclk, adc_lrck, sample_valid, overrun;
   logic signed [15:0] sample_left, sample_right;
   int n_chk = 0, n_fail = 0, cyc = 0, go_cnt = 0;
   logic [15:0] cl = 0, cr = 0;
   logic dly = 0, pad = 0;
   int n = 0, seen_go = 0;
   logic last_lr = 0;
   typedef struct {logic [15:0] l, r; logic d, p; logic [15:0] el, er;} vec_t;
   vec_t vt[5];

   audio_codec_input dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .adc_bclk(adc_bclk), .adc_lrck(adc_lrck),
      .adc_data(adc_data), .sample_left(sample_left), .sample_right(sample_right),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun),
      .clear_overrun(clear_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic codec_bit(input logic lr, input int k);
      logic [15:0] w;
      w = lr ? cr : cl;
      return k == 0 ? dly : (k <= 16 ? w[16-k] : pad);
   endfunction

   // codec slave: drives the next bit after each bclk fall, restarting at a new slot or a go request
   always begin
      @(negedge adc_bclk or go_cnt);
      #1;
      if (go_cnt != seen_go) begin
         seen_go = go_cnt; n = 0; last_lr = 0;
      end else begin
         n = (adc_lrck != last_lr) ? 0 : n + 1;
         last_lr = adc_lrck;
      end
      adc_data = codec_bit(last_lr, n);
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, {15'd0, act}, {15'd0, exp});
   endtask

   task automatic adv_to(input int t);
      repeat (t - cyc) @(posedge clk);
      #1;
      cyc = t;
   endtask

   task automatic start(input logic [15:0] l, input logic [15:0] r, input logic d, input logic p);
      cl = l; cr = r; dly = d; pad = p;
      go_cnt++;
      enable = 1;
      cyc = -1;
   endtask

   task automatic stop();
      enable = 0;
      adv_to(cyc + 4);
   endtask

   task automatic chk_zero(input string nm);
      chk1({nm, " bclk"}, adc_bclk, 0);
      chk1({nm, " lrck"}, adc_lrck, 0);
      chk1({nm, " valid"}, sample_valid, 0);
      chk1({nm, " overrun"}, overrun, 0);
      chk({nm, " left"}, sample_left, 16'h0000);
      chk({nm, " right"}, sample_right, 16'h0000);
   endtask

   initial begin
      vt[0] = '{16'h8001, 16'h7FFE, 1'b0, 1'b0, 16'h8001, 16'h7FFE};
      vt[1] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000};
      vt[2] = '{16'h1234, 16'hABCD, 1'b1, 1'b1, 16'h1234, 16'hABCD};
      vt[3] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000};
      vt[4] = '{16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 16'h5A5A, 16'hA5A5};
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1;
      adv_to(3);
      // first frame timing with a consumer that is always ready
      sample_ready = 1;
      start(16'h8001, 16'h7FFE, 1'b0, 1'b0);
      adv_to(15);   chk1("bclk before rise0", adc_bclk, 0);
      adv_to(16);   chk1("bclk rise0", adc_bclk, 1);
      adv_to(1023); chk1("lrck before slot wrap", adc_lrck, 0);
      adv_to(1024); chk1("lrck at slot wrap", adc_lrck, 1);
                    chk1("bclk at slot wrap", adc_bclk, 0);
      adv_to(1552); chk1("valid before first pair", sample_valid, 0);
      adv_to(1553); chk1("valid first pair", sample_valid, 1);
                    chk("left first pair", sample_left, 16'h8001);
                    chk("right first pair", sample_right, 16'h7FFE);
      adv_to(1554); chk1("valid after transfer", sample_valid, 0);
      adv_to(3600); chk1("valid before second pair", sample_valid, 0);
      adv_to(3601); chk1("valid second pair", sample_valid, 1);
                    chk("left second pair", sample_left, 16'h8001);
      // table of codec patterns, including delay-bit and padding alignment
      for (int i = 0; i < 5; i++) begin
         stop();
         start(vt[i].l, vt[i].r, vt[i].d, vt[i].p);
         adv_to(1553);
         chk1("table valid", sample_valid, 1);
         chk("table left", sample_left, vt[i].el);
         chk("table right", sample_right, vt[i].er);
      end
      // backpressure: second completion is dropped and flags overrun
      stop();
      sample_ready = 0;
      start(16'h1111, 16'h2222, 1'b0, 1'b0);
      adv_to(1553); chk1("bp valid", sample_valid, 1);
                    chk("bp left", sample_left, 16'h1111);
      cl = 16'h3333; cr = 16'h4444;
      adv_to(3600); chk1("bp overrun before", overrun, 0);
      adv_to(3601); chk1("bp overrun set", overrun, 1);
                    chk1("bp valid held", sample_valid, 1);
                    chk("bp left held", sample_left, 16'h1111);
                    chk("bp right held", sample_right, 16'h2222);
      clear_overrun = 1;
      adv_to(3602); chk1("overrun cleared", overrun, 0);
      clear_overrun = 0;
      // ready only in the completion cycle: swap pair without overrun
      adv_to(5648); sample_ready = 1;
      adv_to(5649); sample_ready = 0;
                    chk1("swap valid", sample_valid, 1);
                    chk("swap left", sample_left, 16'h3333);
                    chk("swap right", sample_right, 16'h4444);
                    chk1("swap overrun", overrun, 0);
      adv_to(5650); chk1("swap valid stays", sample_valid, 1);
      // clear in the same cycle as a set: set wins
      adv_to(7696); chk1("overrun before set", overrun, 0);
      clear_overrun = 1;
      adv_to(7697); clear_overrun = 0;
                    chk1("set beats clear", overrun, 1);
                    chk("set-clear left held", sample_left, 16'h3333);
      clear_overrun = 1;
      adv_to(7698); clear_overrun = 0;
                    chk1("overrun cleared again", overrun, 0);
      // drop enable in the right slot at bit 8
      cl = 16'h5555;
      adv_to(9490); chk1("mid bclk high", adc_bclk, 1);
                    chk1("mid lrck right", adc_lrck, 1);
      enable = 0;
      adv_to(9491); chk1("disable bclk", adc_bclk, 0);
                    chk1("disable lrck", adc_lrck, 0);
                    chk1("disable valid kept", sample_valid, 1);
                    chk("disable left kept", sample_left, 16'h3333);
                    chk("disable right kept", sample_right, 16'h4444);
      sample_ready = 1;
      adv_to(9494); chk1("drain after disable", sample_valid, 0);
      start(16'h7777, 16'h0888, 1'b0, 1'b0);
      adv_to(15);   chk1("restart bclk low", adc_bclk, 0);
      adv_to(16);   chk1("restart bclk rise0", adc_bclk, 1);
      adv_to(1552); chk1("restart no early pair", sample_valid, 0);
      adv_to(1553); chk1("restart valid", sample_valid, 1);
                    chk("restart left", sample_left, 16'h7777);
                    chk("restart right", sample_right, 16'h0888);
      sample_ready = 0;
      adv_to(2000); chk1("held before reset", sample_valid, 1);
      // asynchronous reset pulse in the middle of a cycle
      #2 rst_n = 0;
      #1 chk_zero("async reset");
      #2 rst_n = 1;
      start(16'h1357, 16'h2468, 1'b1, 1'b0);
      adv_to(15);   chk1("post-reset bclk low", adc_bclk, 0);
      adv_to(16);   chk1("post-reset bclk rise0", adc_bclk, 1);
      adv_to(1553); chk1("post-reset valid", sample_valid, 1);
                    chk("post-reset left", sample_left, 16'h1357);
                    chk("post-reset right", sample_right, 16'h2468);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
